// File: rtl/sr_imem_loader_if.sv
// Loader/CPU-side bus of the instruction-memory loader: byte stream in, status and
// two instruction read ports out.
interface sr_imem_loader_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              ld_start;
    logic              ld_valid;
    logic              ld_ready;
    logic [7:0]        ld_byte;
    logic              ld_last;
    logic [31:0]       imAddr;
    logic [31:0]       imData;
    logic [31:0]       imData2;
    logic              cpu_rst_n;
    logic              ld_busy;
    logic [ADDR_W:0]   ld_words;
    logic              ld_err;

    modport master (
        output ld_start, ld_valid, ld_byte, ld_last, imAddr,
        input  ld_ready, imData, imData2, cpu_rst_n, ld_busy, ld_words, ld_err
    );

    modport slave (
        input  ld_start, ld_valid, ld_byte, ld_last, imAddr,
        output ld_ready, imData, imData2, cpu_rst_n, ld_busy, ld_words, ld_err
    );
endinterface

// File: rtl/sr_imem_loader.sv
// Loads a little-endian byte stream into instruction memory and holds the CPU in reset
// until the program is complete; exposes two combinational instruction read ports.
module sr_imem_loader #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    sr_imem_loader_if.slave bus
);
    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned WORDS_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

    state_t              state;
    state_t              nextState_c;
    logic [WORDS_W-1:0]  wordCnt;
    logic [1:0]          byteIdx;
    logic [23:0]         asmReg;
    logic                cpuRstN;
    logic                ldReady;
    logic                ldBusy;
    logic                ldErr;
    logic                accept_c;
    logic                full_c;
    logic                wrEn_c;
    logic [31:0]         wrData_c;
    logic [ADDR_W-1:0]   rdAddr2_c;
    logic [31:0]         mem [DEPTH];
    wire                 unusedAddrHi = ^bus.imAddr[31:ADDR_W];

    // Byte acceptance, word completion (with zero fill on early last) and next state
    always_comb begin
        accept_c    = (state == LOAD) && bus.ld_valid && !bus.ld_start;
        full_c      = (wordCnt == WORDS_W'(DEPTH));
        wrEn_c      = accept_c && !full_c && ((byteIdx == 2'd3) || bus.ld_last);
        wrData_c    = {bus.ld_byte, asmReg};
        nextState_c = state;
        unique case (byteIdx)
            2'd0:    wrData_c = {24'h0, bus.ld_byte};
            2'd1:    wrData_c = {16'h0, bus.ld_byte, asmReg[7:0]};
            2'd2:    wrData_c = {8'h0, bus.ld_byte, asmReg[15:0]};
            default: wrData_c = {bus.ld_byte, asmReg};
        endcase
        if (bus.ld_start) begin
            nextState_c = LOAD;
        end else if (accept_c) begin
            if (full_c) begin
                nextState_c = ERR;
            end else if (bus.ld_last) begin
                nextState_c = RUN;
            end
        end
    end

    // State, registered outputs, word counter and byte assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cpuRstN <= 1'b0;
            ldReady <= 1'b0;
            ldBusy  <= 1'b0;
            ldErr   <= 1'b0;
            wordCnt <= '0;
            byteIdx <= '0;
            asmReg  <= '0;
        end else begin
            state   <= nextState_c;
            cpuRstN <= (nextState_c == RUN);
            ldReady <= (nextState_c == LOAD);
            ldBusy  <= (nextState_c == LOAD);
            ldErr   <= (nextState_c == ERR);
            if (bus.ld_start) begin
                wordCnt <= '0;
                byteIdx <= '0;
                asmReg  <= '0;
            end else if (accept_c && !full_c) begin
                if (wrEn_c) begin
                    wordCnt <= wordCnt + WORDS_W'(1);
                    byteIdx <= '0;
                end else begin
                    byteIdx <= byteIdx + 2'd1;
                end
                unique case (byteIdx)
                    2'd0:    asmReg[7:0]   <= bus.ld_byte;
                    2'd1:    asmReg[15:8]  <= bus.ld_byte;
                    2'd2:    asmReg[23:16] <= bus.ld_byte;
                    default: asmReg        <= asmReg;
                endcase
            end
        end
    end

    // Program storage: never reset, so contents survive reset and reloads
    always_ff @(posedge clk) begin
        if (wrEn_c) begin
            mem[wordCnt[ADDR_W-1:0]] <= wrData_c;
        end
    end

    assign rdAddr2_c     = bus.imAddr[ADDR_W-1:0] + ADDR_W'(1);
    assign bus.imData    = mem[bus.imAddr[ADDR_W-1:0]];
    assign bus.imData2   = mem[rdAddr2_c];
    assign bus.cpu_rst_n = cpuRstN;
    assign bus.ld_ready  = ldReady;
    assign bus.ld_busy   = ldBusy;
    assign bus.ld_err    = ldErr;
    assign bus.ld_words  = wordCnt;
endmodule
